// File: rtl/serial_rx_frontend.sv
`timescale 1ns / 1ps
// serial_rx_frontend: 8N1 UART receiver. Synchronises the raw pin, recovers
// frames by mid-bit sampling and presents each byte on a one-entry
// valid/ready holding register with framing-error and overrun reporting.
module serial_rx_frontend #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       serial_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       overrun_clr,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfM1 = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] BitM1  = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            busy_q, busy_d;
  logic            deliver;
  logic            accept;

  // Shift the raw pin through the synchroniser chain; idle level is high
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], serial_in};
    end
  end

  assign rxs = sync_q[SYNC_STAGES-1];

  // Receiver FSM next state: counter, bit index and shift register
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CntW'(1);
    bit_d       = bit_q;
    shift_d     = shift_q;
    deliver     = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rxs) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == HalfM1) begin
          cnt_d = '0;
          if (!rxs) begin
            state_d = StData;
            bit_d   = 3'd0;
          end else begin
            // Start bit gone by mid-bit: a glitch, not a frame
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (cnt_q == BitM1) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = StStop;
        end
      end
      StStop: begin
        if (cnt_q == BitM1) begin
          cnt_d = '0;
          if (rxs) begin
            deliver = 1'b1;
            state_d = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StBreak;
          end
        end
      end
      StBreak: begin
        // Hold off until the line returns high so a stuck-low line is one error
        cnt_d = '0;
        if (rxs) state_d = StIdle;
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // Holding register, overrun flag and registered busy
  always_comb begin
    accept     = rx_valid_q & rx_ready;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    if (overrun_clr) overrun_d = 1'b0;
    if (deliver) begin
      if (!rx_valid_q || accept) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        // Set wins over a simultaneous clear
        overrun_d = 1'b1;
      end
    end else if (accept) begin
      rx_valid_d = 1'b0;
    end
    busy_d = (state_d != StIdle);
  end

  // State registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_q       <= 3'd0;
      shift_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_serial_rx_frontend.sv
`timescale 1ns / 1ps
// Testbench for serial_rx_frontend at 16 clocks per bit.
module tb_serial_rx_frontend;

  localparam int unsigned Cpb    = 16;
  localparam int unsigned Sync   = 2;
  localparam real         BitNs  = 160.0;
  localparam int unsigned LatExp = Sync + 1 + Cpb / 2 + 9 * Cpb;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       serial_in = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       frame_err;
  logic       overrun;
  logic       overrun_clr = 1'b0;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] got_q[$];
  int         ferr_cnt   = 0;
  int         valid_rise = 0;
  logic       prev_valid = 1'b0;
  logic       busy_seen  = 1'b0;

  serial_rx_frontend #(
    .CLKS_PER_BIT(Cpb),
    .SYNC_STAGES (Sync)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .serial_in  (serial_in),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .overrun_clr(overrun_clr),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  // Observe handshakes, error pulses and valid rising edges mid-cycle
  always @(negedge CLK) begin
    if (RST) begin
      prev_valid = 1'b0;
    end else begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (frame_err) ferr_cnt++;
      if (rx_valid && !prev_valid) valid_rise++;
      if (busy) busy_seen = 1'b1;
      prev_valid = rx_valid;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  // Drive one 8N1 frame; the line is left at the stop-bit level
  task automatic send_byte(input logic [7:0] b, input logic stop, input real bit_ns);
    serial_in = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      #(bit_ns);
    end
    serial_in = stop;
    #(bit_ns);
  endtask

  task automatic clear_obs();
    got_q.delete();
    ferr_cnt   = 0;
    valid_rise = 0;
    busy_seen  = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    settle(3);
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset rx_data: got %h want 00", rx_data); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset rx_valid: got %b want 0", rx_valid); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset frame_err: got %b want 0", frame_err); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset overrun: got %b want 0", overrun); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
    RST = 1'b0;
    settle(5);
  endtask

  task automatic test_single();
    int lat;
    logic found;
    rx_ready = 1'b0;
    clear_obs();
    lat   = 0;
    found = 1'b0;
    @(posedge CLK); #1;
    fork
      send_byte(8'hA5, 1'b1, BitNs);
      begin
        for (int i = 0; i < 400 && !found; i++) begin
          @(posedge CLK); #1;
          lat++;
          if (rx_valid) found = 1'b1;
        end
      end
    join
    settle(20);
    n_checks++; if (found !== 1'b1 || lat != LatExp) begin n_fail++; $display("FAIL single latency: got %0d (found=%b) want %0d", lat, found, LatExp); end
    n_checks++; if (valid_rise != 1) begin n_fail++; $display("FAIL single valid rises: got %0d want 1", valid_rise); end
    n_checks++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL single rx_data: got %h want a5", rx_data); end
    n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL single rx_valid held: got %b want 1", rx_valid); end
    n_checks++; if (ferr_cnt != 0) begin n_fail++; $display("FAIL single frame_err pulses: got %0d want 0", ferr_cnt); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL single overrun: got %b want 0", overrun); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single busy after stop: got %b want 0", busy); end
    rx_ready = 1'b1;
    settle(1);
    rx_ready = 1'b0;
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL single consume: rx_valid got %b want 0", rx_valid); end
    n_checks++; if (got_q.size() != 1) begin n_fail++; $display("FAIL single handshakes: got %0d want 1", got_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    exp_q = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h3C};
    rx_ready = 1'b1;
    clear_obs();
    @(posedge CLK); #1;
    foreach (exp_q[i]) send_byte(exp_q[i], 1'b1, BitNs);
    settle(40);
    n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b byte %0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b overrun: got %b want 0", overrun); end
    n_checks++; if (ferr_cnt != 0) begin n_fail++; $display("FAIL b2b frame_err pulses: got %0d want 0", ferr_cnt); end
  endtask

  task automatic test_overrun();
    rx_ready = 1'b0;
    clear_obs();
    @(posedge CLK); #1;
    send_byte(8'h12, 1'b1, BitNs);
    send_byte(8'h34, 1'b1, BitNs);
    settle(40);
    n_checks++; if (rx_data !== 8'h12) begin n_fail++; $display("FAIL overrun rx_data kept: got %h want 12", rx_data); end
    n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL overrun rx_valid: got %b want 1", rx_valid); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun flag: got %b want 1", overrun); end
    overrun_clr = 1'b1;
    rx_ready    = 1'b1;
    settle(1);
    overrun_clr = 1'b0;
    rx_ready    = 1'b0;
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL overrun drain rx_valid: got %b want 0", rx_valid); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun clear: got %b want 0", overrun); end
    n_checks++; if (got_q.size() != 1 || got_q[0] !== 8'h12) begin n_fail++; $display("FAIL overrun consumed: got %0d bytes first %h want 1 byte 12", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx); end
  endtask

  task automatic test_frame_err();
    rx_ready = 1'b1;
    clear_obs();
    @(posedge CLK); #1;
    send_byte(8'h81, 1'b0, BitNs);
    #400;
    serial_in = 1'b1;
    settle(20);
    send_byte(8'h7E, 1'b1, BitNs);
    settle(40);
    n_checks++; if (ferr_cnt != 1) begin n_fail++; $display("FAIL ferr pulse cycles: got %0d want 1", ferr_cnt); end
    n_checks++; if (got_q.size() != 1 || got_q[0] !== 8'h7E) begin n_fail++; $display("FAIL ferr next byte: got %0d bytes first %h want 1 byte 7e", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx); end
    n_checks++; if (valid_rise != 1) begin n_fail++; $display("FAIL ferr valid rises: got %0d want 1", valid_rise); end
  endtask

  task automatic test_glitch_skew();
    real skews[2];
    skews[0] = BitNs * 1.02;
    skews[1] = BitNs * 0.98;
    rx_ready = 1'b1;
    clear_obs();
    @(posedge CLK); #1;
    serial_in = 1'b0;
    #50;
    serial_in = 1'b1;
    settle(40);
    n_checks++; if (busy_seen !== 1'b1) begin n_fail++; $display("FAIL glitch start seen: busy got %b want 1", busy_seen); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch back to idle: busy got %b want 0", busy); end
    n_checks++; if (valid_rise != 0 || ferr_cnt != 0) begin n_fail++; $display("FAIL glitch flags: rises %0d ferr %0d want 0 0", valid_rise, ferr_cnt); end
    for (int s = 0; s < 2; s++) begin
      clear_obs();
      send_byte(8'hC3, 1'b1, skews[s]);
      settle(40);
      n_checks++; if (got_q.size() != 1 || got_q[0] !== 8'hC3) begin n_fail++; $display("FAIL skew %0d: got %0d bytes first %h want 1 byte c3", s, got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx); end
    end
  endtask

  // Random bytes, occasional bad stop bits and idle gaps against a queue model
  task automatic test_random();
    logic [7:0] exp_q[$];
    int         exp_ferr;
    logic [7:0] b;
    logic       good;
    int         gap;
    exp_ferr = 0;
    rx_ready = 1'b1;
    clear_obs();
    @(posedge CLK); #1;
    for (int n = 0; n < 16; n++) begin
      b    = 8'($urandom);
      good = ($urandom_range(0, 4) != 0);
      send_byte(b, good, BitNs);
      if (good) begin
        exp_q.push_back(b);
        gap = $urandom_range(0, 2);
      end else begin
        exp_ferr++;
        serial_in = 1'b1;
        gap = 1 + $urandom_range(0, 1);
      end
      if (gap > 0) #(BitNs * gap);
    end
    settle(40);
    n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL random count: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL random byte %0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_checks++; if (ferr_cnt != exp_ferr) begin n_fail++; $display("FAIL random frame_err: got %0d want %0d", ferr_cnt, exp_ferr); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL random overrun: got %b want 0", overrun); end
  endtask

  task automatic test_reset_mid();
    rx_ready = 1'b0;
    clear_obs();
    @(posedge CLK); #1;
    fork
      send_byte(8'h99, 1'b1, BitNs);
      begin
        #(BitNs * 5.0 + BitNs / 2.0);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midreset busy before: got %b want 1", busy); end
        RST = 1'b1;
      end
    join
    #1;
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL midreset rx_data: got %h want 00", rx_data); end
    n_checks++; if (rx_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midreset valid/busy: got %b/%b want 0/0", rx_valid, busy); end
    n_checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin n_fail++; $display("FAIL midreset flags: got %b/%b want 0/0", frame_err, overrun); end
    settle(3);
    RST = 1'b0;
    settle(40);
    n_checks++; if (valid_rise != 0 || ferr_cnt != 0) begin n_fail++; $display("FAIL midreset aftermath: rises %0d ferr %0d want 0 0", valid_rise, ferr_cnt); end
    rx_ready = 1'b1;
    @(posedge CLK); #1;
    send_byte(8'h66, 1'b1, BitNs);
    settle(40);
    n_checks++; if (got_q.size() != 1 || got_q[0] !== 8'h66) begin n_fail++; $display("FAIL midreset next frame: got %0d bytes first %h want 1 byte 66", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_frame_err();
    test_glitch_skew();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
